fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch unit with a prefetch buffer, replacing the single-word fetch stage between instruction memory and decode. It streams sequential words from instruction memory into a DEPTH-entry FIFO and presents decode with a pair: the current word plus the following word, for two-word (immediate-extended) instructions. It also supports back-pressure from decode, variable-length consumption (1 or 2 words) and branch redirect with flush.

## Interface
- ADDR_W, 32, instruction address width
- INSTR_W, 32, instruction word width
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- RESET_PC, 0, first fetch address after reset
- clk  in  1  clock
- reset  in  1  synchronous, active-high; one clock, all state cleared on the rising edge while high
- in_mem_addr  out  ADDR_W  word-aligned fetch address
- in_mem_en  out  1  fetch request; memory returns data exactly one cycle later
- in_mem  in  INSTR_W  fetched word, valid the cycle after in_mem_en
- instr_valid  out  1  instr/instr_next/pc are meaningful
- instr  out  INSTR_W  FIFO head word
- instr_next  out  INSTR_W  word at head+1
- pc  out  ADDR_W  address of instr
- pc_next  out  ADDR_W  pc + 4·(instr_len+1)
- instr_ready  in  1  decode consumes this cycle
- instr_len  in  1  0 = consume 1 word, 1 = consume 2 words
- redirect  in  1  branch taken / flush
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored

## Operation
- State: fetch_pc, head_pc, rd/wr pointers (log2(DEPTH)+1 bits, wrapping), count, inflight flag, drop flag.
- Issue: in_mem_en = !reset && !redirect && (count + inflight < DEPTH). Each issue increments fetch_pc by 4 (ADDR_W wrap-around). It does not credit same-cycle pops.
- Response: if inflight && !drop && !redirect, push in_mem at wr_ptr.
- instr_valid = (count ≥ 2). Output is combinational from FIFO storage.
- Dequeue when instr_valid && instr_ready && !redirect. Pop instr_len+1 entries; head_pc += 4·(instr_len+1).
- Push and pop in the same cycle are legal; count changes by push − pop.
- Redirect: count and pointers cleared; fetch_pc and head_pc ← {redirect_pc[ADDR_W-1:2], 2'b00}. drop is set if a request was in flight, so the returning word is discarded. Dequeue is ignored that cycle. Issue restarts the next cycle.
- Back-to-back redirects: the last one wins. Each redirect cancels everything before it.
- Reset values: in_mem_en=0, in_mem_addr=RESET_PC, instr_valid=0, instr=instr_next=0 (storage cleared), pc=RESET_PC, pc_next=RESET_PC+4.

## Timing
- Reset released before cycle 0:
  - Cycle 0: issue RESET_PC.
  - Cycle 1: issue +4; word0 pushed at end of cycle.
  - Cycle 2: word1 pushed.
  - Cycle 3: instr_valid=1.
- Redirect in cycle r: issue redirect_pc in r+1, and instr_valid earliest in r+4.
- Sustained throughput: 1 word/cycle. A 2-word consume at full rate stalls decode for 1 cycle out of every 2.
- With DEPTH=2, at most one request is in flight; the FIFO is never overrun.

## Configuration
- FETCH_STATS_EN defined adds these outputs, cleared on reset and wrapping:
  - stall_cycles (32-bit): increments each cycle instr_valid=0 outside reset.
  - redirect_count (32-bit): increments per redirect cycle.
- Undefined: ports and counters are absent; the rest is unchanged.

## Structure
- Shared package fetch_pkg:
  - instruction word/address typedefs
  - WORD_BYTES=4
  - len encoding constants (LEN_1W, LEN_2W)
- One sub-module, fetch_fifo: storage plus pointers. It supports push, pop of 1 or 2, flush, count, and head/head+1 read.
- Issue/redirect control stays in fetch_queue.

## Test plan
- Reset, RESET_PC=0x100, memory returns addr-as-data, instr_ready=0 → requests 0x100..0x10C then in_mem_en=0. instr_valid in cycle 3 with instr=0x100, instr_next=0x104, pc_next=0x104.
- instr_ready=1, instr_len alternating 0/1 → pc sequence 0x100, 0x104, 0x10C, 0x110…, no word lost or duplicated.
- Redirect to 0x203 while a request is in flight → next request 0x200, stale word dropped, first instr=0x200 in cycle r+4.
- Redirect and instr_ready in the same cycle → no pop counted; head_pc=redirect target.
- DEPTH=2, decode stalled 20 cycles then released → never more than 2 stored, in_mem_en low while full, stream resumes in order.
- fetch_pc wrap at 0xFFFFFFFC → next request 0x00000000. With FETCH_STATS_EN: stall_cycles=3 after the initial fill, redirect_count=1 after one redirect.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [XLEN-1:0] word_t;

  // instr_len encoding: words consumed by decode in one handshake
  localparam logic LEN_1W = 1'b0;
  localparam logic LEN_2W = 1'b1;

  function automatic int unsigned len_words(input logic len);
    return (len == LEN_2W) ? 2 : 1;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Memory-side and decode-side signals of the fetch unit, bundled for port use.
interface fetch_queue_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
) ();

  logic [ADDR_W-1:0]  in_mem_addr;
  logic               in_mem_en;
  logic [INSTR_W-1:0] in_mem;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [INSTR_W-1:0] instr_next;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_next;
  logic               instr_ready;
  logic               instr_len;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;

  modport master (
    output in_mem_addr, in_mem_en, instr_valid, instr, instr_next, pc, pc_next,
    input  in_mem, instr_ready, instr_len, redirect, redirect_pc
  );

  modport slave (
    input  in_mem_addr, in_mem_en, instr_valid, instr, instr_next, pc, pc_next,
    output in_mem, instr_ready, instr_len, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: single push, pop of 1 or 2, flush, and head/head+1 read ports.
module fetch_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned INSTR_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [INSTR_W-1:0]         push_data,
  input  logic                       pop,
  input  logic                       pop_two,
  output logic [$clog2(DEPTH):0]     count,
  output logic [INSTR_W-1:0]         head,
  output logic [INSTR_W-1:0]         head_next
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PW:0]        rd_ptr_q, wr_ptr_q;
  logic [PW:0]        pop_n;
  logic [PW-1:0]      rd_idx, rd_idx_next;

  assign pop_n       = !pop ? '0 : (pop_two ? (PW+1)'(2) : (PW+1)'(1));
  assign rd_idx      = rd_ptr_q[PW-1:0];
  assign rd_idx_next = rd_idx + PW'(1);

  // Pointers carry one extra wrap bit so full and empty stay distinct.
  assign count     = wr_ptr_q - rd_ptr_q;
  assign head      = mem_q[rd_idx];
  assign head_next = mem_q[rd_idx_next];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[PW-1:0]] <= push_data;
        wr_ptr_q                <= wr_ptr_q + (PW+1)'(1);
      end
      rd_ptr_q <= rd_ptr_q + pop_n;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch unit with prefetch FIFO, two-word decode window and branch redirect.
// Defining FETCH_STATS_EN adds the stall_cycles and redirect_count counter outputs.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   redirect_count
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, head_pc_q;
  logic [ADDR_W-1:0] redirect_base, step;
  logic              inflight_q, drop_q;
  logic              issue, push, pop, valid;
  logic [PW:0]       count;
  logic [PW+1:0]     occupancy;
  logic              unused_bits;

  assign redirect_base = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_bits   = ^bus.redirect_pc[1:0];

  // Reserve a slot for the outstanding request; same-cycle pops are not credited.
  assign occupancy = {1'b0, count} + (PW+2)'(inflight_q);
  assign issue     = !reset && !bus.redirect && (occupancy < (PW+2)'(DEPTH));
  assign valid     = count >= (PW+1)'(2);
  assign pop       = valid && bus.instr_ready && !bus.redirect;
  assign push      = inflight_q && !drop_q && !bus.redirect;
  assign step      = (bus.instr_len == LEN_2W) ? ADDR_W'(2 * WORD_BYTES) : ADDR_W'(WORD_BYTES);

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect),
    .push      (push),
    .push_data (bus.in_mem),
    .pop       (pop),
    .pop_two   (bus.instr_len == LEN_2W),
    .count     (count),
    .head      (bus.instr),
    .head_next (bus.instr_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      inflight_q <= issue;
      drop_q     <= bus.redirect && inflight_q;
      if (bus.redirect) begin
        fetch_pc_q <= redirect_base;
        head_pc_q  <= redirect_base;
      end else begin
        if (issue) fetch_pc_q <= fetch_pc_q + ADDR_W'(WORD_BYTES);
        if (pop)   head_pc_q  <= head_pc_q + step;
      end
    end
  end

  assign bus.in_mem_addr = fetch_pc_q;
  assign bus.in_mem_en   = issue;
  assign bus.instr_valid = valid;
  assign bus.pc          = head_pc_q;
  assign bus.pc_next     = head_pc_q + step;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if (!valid)       stall_cycles   <= stall_cycles + 32'd1;
      if (bus.redirect) redirect_count <= redirect_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: fill-table vectors, redirect/wrap sequences, DEPTH=2 stall, random vs model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned DEPTH_A = 4;
  localparam addr_t       RESET_A = 32'h100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  fetch_queue_if #(.ADDR_W(32), .INSTR_W(32)) fa ();
  fetch_queue_if #(.ADDR_W(32), .INSTR_W(32)) fb ();

`ifdef FETCH_STATS_EN
  logic [31:0] a_stall, a_redir, b_stall, b_redir;
`endif

  fetch_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH_A), .RESET_PC(RESET_A)) u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (fa)
`ifdef FETCH_STATS_EN
    , .stall_cycles (a_stall), .redirect_count (a_redir)
`endif
  );

  fetch_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(2), .RESET_PC(32'h0)) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (fb)
`ifdef FETCH_STATS_EN
    , .stall_cycles (b_stall), .redirect_count (b_redir)
`endif
  );

  // Memory returns the address as data, one cycle after the request.
  always @(posedge clk) begin
    fa.in_mem <= fa.in_mem_en ? fa.in_mem_addr : 32'hDEAD_BEEF;
    fb.in_mem <= fb.in_mem_en ? fb.in_mem_addr : 32'hDEAD_BEEF;
  end

  // Reference model: stored words, at most one pending request, fetch/head addresses.
  word_t mq[$];
  bit    m_pend;
  word_t m_pend_d;
  addr_t m_fpc, m_hpc;

  typedef struct {
    logic  ready;
    logic  len;
    logic  en;
    addr_t addr;
    logic  valid;
    word_t instr;
    word_t instr_next;
    addr_t pc;
    addr_t pc_next;
  } vec_t;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic drive_a(input logic rdy, input logic len, input logic rd, input addr_t rpc);
    fa.instr_ready = rdy;
    fa.instr_len   = len;
    fa.redirect    = rd;
    fa.redirect_pc = rpc;
  endtask

  task automatic check_model_a();
    logic  exp_en, exp_valid;
    addr_t inc;
    exp_en    = !fa.redirect && ((mq.size() + (m_pend ? 1 : 0)) < int'(DEPTH_A));
    exp_valid = mq.size() >= 2;
    inc       = fa.instr_len ? 32'd8 : 32'd4;
    chk("m_en", fa.in_mem_en, exp_en);
    if (exp_en) chk("m_addr", fa.in_mem_addr, m_fpc);
    chk("m_valid", fa.instr_valid, exp_valid);
    chk("m_pc", fa.pc, m_hpc);
    chk("m_pc_next", fa.pc_next, m_hpc + inc);
    if (exp_valid) begin
      chk("m_instr", fa.instr, mq[0]);
      chk("m_instr_next", fa.instr_next, mq[1]);
    end
  endtask

  // Drive inputs just after a falling edge, then compare against the model.
  task automatic cyc_a(input logic rdy, input logic len, input logic rd, input addr_t rpc);
    drive_a(rdy, len, rd, rpc);
    #1;
    check_model_a();
  endtask

  task automatic advance_a();
    bit issue;
    int n;
    @(posedge clk);
    if (fa.redirect) begin
      mq.delete();
      m_pend = 1'b0;
      m_fpc  = fa.redirect_pc & ~32'h3;
      m_hpc  = fa.redirect_pc & ~32'h3;
    end else begin
      issue = (mq.size() + (m_pend ? 1 : 0)) < int'(DEPTH_A);
      if (mq.size() >= 2 && fa.instr_ready) begin
        n = int'(len_words(fa.instr_len));
        repeat (n) void'(mq.pop_front());
        m_hpc += addr_t'(4 * n);
      end
      if (m_pend) mq.push_back(m_pend_d);
      m_pend = issue;
      if (issue) begin
        m_pend_d = m_fpc;
        m_fpc += 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    drive_a(1'b0, 1'b0, 1'b0, '0);
    fb.instr_ready = 1'b0;
    fb.instr_len   = 1'b0;
    fb.redirect    = 1'b0;
    fb.redirect_pc = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_en", fa.in_mem_en, 1'b0);
    chk("rst_addr", fa.in_mem_addr, RESET_A);
    chk("rst_valid", fa.instr_valid, 1'b0);
    chk("rst_instr", fa.instr, 32'h0);
    chk("rst_instr_next", fa.instr_next, 32'h0);
    chk("rst_pc", fa.pc, RESET_A);
    chk("rst_pc_next", fa.pc_next, RESET_A + 32'd4);
    chk("rst_b_pc_next", fb.pc_next, 32'h4);
`ifdef FETCH_STATS_EN
    chk("rst_stall_cycles", a_stall, 32'h0);
`endif
    reset = 1'b0;
    mq.delete();
    m_pend = 1'b0;
    m_fpc  = RESET_A;
    m_hpc  = RESET_A;
  endtask

  initial begin
    vec_t tbl[11];
    int   n_req, got;
    word_t exp_w;

    tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   32'h0,   32'h100, 32'h104};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'h104, 1'b0, 32'h0,   32'h0,   32'h100, 32'h104};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'h108, 1'b0, 32'h0,   32'h0,   32'h100, 32'h104};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h10C, 1'b1, 32'h100, 32'h104, 32'h100, 32'h104};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h110, 1'b1, 32'h100, 32'h104, 32'h100, 32'h104};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h110, 1'b1, 32'h100, 32'h104, 32'h100, 32'h104};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h110, 1'b1, 32'h100, 32'h104, 32'h100, 32'h104};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 32'h110, 1'b1, 32'h104, 32'h108, 32'h104, 32'h10C};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'h114, 1'b0, 32'h0,   32'h0,   32'h10C, 32'h110};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h118, 1'b1, 32'h10C, 32'h110, 32'h10C, 32'h110};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h11C, 1'b1, 32'h110, 32'h114, 32'h110, 32'h118};

    // Initial fill and alternating-length consumption
    apply_reset();
    for (int k = 0; k < 11; k++) begin
      cyc_a(tbl[k].ready, tbl[k].len, 1'b0, '0);
      chk("tbl_en", fa.in_mem_en, tbl[k].en);
      chk("tbl_addr", fa.in_mem_addr, tbl[k].addr);
      chk("tbl_valid", fa.instr_valid, tbl[k].valid);
      chk("tbl_pc", fa.pc, tbl[k].pc);
      chk("tbl_pc_next", fa.pc_next, tbl[k].pc_next);
      if (tbl[k].valid) begin
        chk("tbl_instr", fa.instr, tbl[k].instr);
        chk("tbl_instr_next", fa.instr_next, tbl[k].instr_next);
      end
`ifdef FETCH_STATS_EN
      if (k == 3) chk("stall_cycles", a_stall, 32'd3);
`endif
      advance_a();
    end

    // Redirect while a request is in flight
    apply_reset();
    cyc_a(1'b0, 1'b0, 1'b0, '0);
    advance_a();
    cyc_a(1'b0, 1'b0, 1'b1, 32'h203);
    chk("redir_en_low", fa.in_mem_en, 1'b0);
    advance_a();
`ifdef FETCH_STATS_EN
    chk("redirect_count", a_redir, 32'd1);
`endif
    cyc_a(1'b0, 1'b0, 1'b0, '0);
    chk("redir_en", fa.in_mem_en, 1'b1);
    chk("redir_addr", fa.in_mem_addr, 32'h200);
    chk("redir_r1_valid", fa.instr_valid, 1'b0);
    advance_a();
    for (int k = 0; k < 2; k++) begin
      cyc_a(1'b0, 1'b0, 1'b0, '0);
      chk("redir_wait_valid", fa.instr_valid, 1'b0);
      advance_a();
    end
    cyc_a(1'b0, 1'b0, 1'b0, '0);
    chk("redir_r4_valid", fa.instr_valid, 1'b1);
    chk("redir_r4_instr", fa.instr, 32'h200);
    chk("redir_r4_next", fa.instr_next, 32'h204);
    advance_a();

    // Redirect and consume in the same cycle: no pop, head follows the target
    cyc_a(1'b1, 1'b1, 1'b1, 32'h300);
    advance_a();
    cyc_a(1'b0, 1'b0, 1'b0, '0);
    chk("same_pc", fa.pc, 32'h300);
    chk("same_pc_next", fa.pc_next, 32'h304);
    advance_a();
    repeat (2) begin
      cyc_a(1'b0, 1'b0, 1'b0, '0);
      advance_a();
    end
    cyc_a(1'b0, 1'b0, 1'b0, '0);
    chk("same_instr", fa.instr, 32'h300);
    advance_a();

    // Fetch address wrap
    cyc_a(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF9);
    advance_a();
    cyc_a(1'b0, 1'b0, 1'b0, '0);
    chk("wrap_a0", fa.in_mem_addr, 32'hFFFF_FFF8);
    advance_a();
    cyc_a(1'b0, 1'b0, 1'b0, '0);
    chk("wrap_a1", fa.in_mem_addr, 32'hFFFF_FFFC);
    advance_a();
    cyc_a(1'b0, 1'b0, 1'b0, '0);
    chk("wrap_a2", fa.in_mem_addr, 32'h0);
    advance_a();
    cyc_a(1'b1, 1'b1, 1'b0, '0);
    chk("wrap_pc_next", fa.pc_next, 32'h0);
    advance_a();

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      logic  rd;
      addr_t rpc;
      rd  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | addr_t'($urandom_range(0, 15)))
                                        : addr_t'($urandom);
      cyc_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rd, rpc);
      advance_a();
    end

    // DEPTH=2: stall decode 20 cycles, then release
    apply_reset();
    n_req = 0;
    for (int k = 0; k < 20; k++) begin
      fb.instr_ready = 1'b0;
      #1;
      if (fb.in_mem_en) n_req++;
      if (fb.instr_valid) chk("b_en_while_full", fb.in_mem_en, 1'b0);
      @(negedge clk);
    end
    chk("b_stall_requests", n_req, 32'd2);
    chk("b_full_valid", fb.instr_valid, 1'b1);
    exp_w = '0;
    got   = 0;
    for (int k = 0; k < 80 && got < 16; k++) begin
      fb.instr_ready = 1'b1;
      fb.instr_len   = LEN_1W;
      #1;
      if (fb.instr_valid) begin
        chk("b_stream", fb.instr, exp_w);
        chk("b_en_while_full", fb.in_mem_en, 1'b0);
        exp_w += 32'd4;
        got++;
      end
      @(negedge clk);
    end
    chk("b_words", got, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
